// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill level, almost-full/almost-empty flags, optional
// first-word-fall-through read port and sticky overflow/underflow flags.
module sync_fifo_ctrl #(
    parameter int DATA_SIZE = 12,
    parameter int ADDR_SIZE = 4,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 2**ADDR_SIZE - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 winc,
    input  logic [DATA_SIZE-1:0] wData,
    input  logic                 rinc,
    input  logic                 errClr,
    output logic [DATA_SIZE-1:0] rData,
    output logic                 wFull,
    output logic                 rEmpty,
    output logic                 wAlmostFull,
    output logic                 rAlmostEmpty,
    output logic [ADDR_SIZE:0]   fillCount,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 2**ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(AF_THRESH);
    localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(AE_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_range
        $error("sync_fifo_ctrl: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_range
        $error("sync_fifo_ctrl: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE:0]   wptr, rptr, count;
    logic [ADDR_SIZE:0]   rptr_nxt, count_nxt;
    logic                 wr_acc, rd_acc, head_is_new;

    assign wFull        = (count == DEPTH_C);
    assign rEmpty       = (count == '0);
    assign wAlmostFull  = (count >= AF_C);
    assign rAlmostEmpty = (count <= AE_C);
    assign fillCount    = count;

    assign wr_acc = winc && !wFull;
    assign rd_acc = rinc && !rEmpty;

    always_comb begin
        rptr_nxt    = rptr + {{ADDR_SIZE{1'b0}}, rd_acc};
        count_nxt   = count + {{ADDR_SIZE{1'b0}}, wr_acc} - {{ADDR_SIZE{1'b0}}, rd_acc};
        // The word landing this edge becomes the head only if nothing older survives it.
        head_is_new = (count == {{ADDR_SIZE{1'b0}}, rd_acc});
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr[ADDR_SIZE-1:0]] <= wData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            rptr  <= rptr_nxt;
            count <= count_nxt;
            if (winc && wFull)  overflow  <= 1'b1;
            else if (errClr)    overflow  <= 1'b0;
            if (rinc && rEmpty) underflow <= 1'b1;
            else if (errClr)    underflow <= 1'b0;
        end
    end

    // Read port: registered pop in standard mode, pre-fetched head in FWFT mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            rData <= '0;
        end else if (FWFT != 0) begin
            if (count_nxt != '0) begin
                if (head_is_new) rData <= wData;
                else             rData <= mem[rptr_nxt[ADDR_SIZE-1:0]];
            end
        end else if (rd_acc) begin
            rData <= mem[rptr[ADDR_SIZE-1:0]];
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench: a standard-mode and an FWFT-mode FIFO driven with the same inputs.
module tb_sync_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst, winc, rinc, errClr;
    logic [DW-1:0] wData;

    logic [DW-1:0] rdata0, rdata1;
    logic          full0, empty0, afull0, aempty0, ovf0, udf0;
    logic [AW:0]   fill0;
    logic          full1, empty1, afull1, aempty1, ovf1, udf1;
    logic [AW:0]   fill1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_std (
        .clk(clk), .rst(rst), .winc(winc), .wData(wData), .rinc(rinc), .errClr(errClr),
        .rData(rdata0), .wFull(full0), .rEmpty(empty0), .wAlmostFull(afull0),
        .rAlmostEmpty(aempty0), .fillCount(fill0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .winc(winc), .wData(wData), .rinc(rinc), .errClr(errClr),
        .rData(rdata1), .wFull(full1), .rEmpty(empty1), .wAlmostFull(afull1),
        .rAlmostEmpty(aempty1), .fillCount(fill1), .overflow(ovf1), .underflow(udf1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        winc = 1'b0; rinc = 1'b0; errClr = 1'b0; rst = 1'b0;
    endtask

    initial begin
        idle();
        wData = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        check_eq("rst_empty",  empty0,  1);
        check_eq("rst_aempty", aempty0, 1);
        check_eq("rst_full",   full0,   0);
        check_eq("rst_afull",  afull0,  0);
        check_eq("rst_fill",   fill0,   0);
        check_eq("rst_rdata",  rdata0,  0);
        check_eq("rst_rdataf", rdata1,  0);
        check_eq("rst_ovf",    ovf0,    0);
        check_eq("rst_udf",    udf0,    0);

        // fill with 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            winc = 1'b1; wData = DW'(i);
            tick();
            check_eq("fill_cnt",    fill0,   i);
            check_eq("fill_aempty", aempty0, (i <= 2) ? 1 : 0);
            check_eq("fill_afull",  afull0,  (i >= 6) ? 1 : 0);
            check_eq("fill_full",   full0,   (i == 8) ? 1 : 0);
            check_eq("fill_fwft",   rdata1,  8'h01);
        end

        // write while full
        winc = 1'b1; wData = 8'h99;
        tick();
        idle();
        check_eq("ovf_set",  ovf0,  1);
        check_eq("ovf_fill", fill0, 8);
        errClr = 1'b1;
        tick();
        idle();
        check_eq("ovf_clr", ovf0, 0);

        // drain, contents must be untouched by the rejected write
        for (int i = 1; i <= 8; i++) begin
            rinc = 1'b1;
            tick();
            check_eq("drain_data", rdata0, i);
            check_eq("drain_cnt",  fill0,  8 - i);
            check_eq("drain_fwft", rdata1, (i < 8) ? i + 1 : 8);
        end
        check_eq("drain_empty", empty0, 1);

        // read while empty: underflow, rData held; set beats a simultaneous clear
        rinc = 1'b1;
        tick();
        check_eq("udf_set",   udf0,   1);
        check_eq("udf_hold",  rdata0, 8'h08);
        check_eq("udf_fill",  fill0,  0);
        rinc = 1'b1; errClr = 1'b1;
        tick();
        check_eq("udf_setwins", udf0, 1);
        rinc = 1'b0;
        tick();
        idle();
        check_eq("udf_clr", udf0, 0);

        // full + simultaneous read/write
        for (int i = 0; i < 8; i++) begin
            winc = 1'b1; wData = 8'h11 + DW'(i);
            tick();
        end
        winc = 1'b1; rinc = 1'b1; wData = 8'hAA;
        tick();
        idle();
        check_eq("frw_data", rdata0, 8'h11);
        check_eq("frw_fill", fill0,  7);
        check_eq("frw_ovf",  ovf0,   1);
        check_eq("frw_fwft", rdata1, 8'h12);
        for (int i = 0; i < 7; i++) begin
            rinc = 1'b1;
            tick();
            check_eq("frw_drain", rdata0, 8'h12 + i);
        end
        idle();
        check_eq("frw_empty", empty0, 1);
        errClr = 1'b1;
        tick();
        idle();

        // empty + simultaneous read/write; FWFT shows the word with no request
        winc = 1'b1; rinc = 1'b1; wData = 8'h5C;
        tick();
        idle();
        check_eq("erw_fill",   fill0,  1);
        check_eq("erw_udf",    udf0,   1);
        check_eq("erw_hold",   rdata0, 8'h18);
        check_eq("fwft_empty", empty1, 0);
        check_eq("fwft_data",  rdata1, 8'h5C);
        rinc = 1'b1;
        tick();
        idle();
        check_eq("fwft_pop_empty", empty1, 1);
        check_eq("fwft_pop_fill",  fill1,  0);
        check_eq("std_pop_data",   rdata0, 8'h5C);
        errClr = 1'b1;
        tick();
        idle();

        // steady count 3 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            winc = 1'b1; wData = 8'h40 + DW'(i);
            tick();
        end
        for (int j = 0; j < 20; j++) begin
            winc = 1'b1; rinc = 1'b1; wData = 8'h43 + DW'(j);
            tick();
            check_eq("wrap_data", rdata0, 8'h40 + j);
            check_eq("wrap_fwft", rdata1, 8'h41 + j);
            check_eq("wrap_fill", fill0,  3);
        end

        // reset mid-stream
        rst = 1'b1;
        tick();
        idle();
        check_eq("mrst_fill",  fill0,  0);
        check_eq("mrst_empty", empty0, 1);
        check_eq("mrst_rdata", rdata0, 0);
        check_eq("mrst_ovf",   ovf0 | udf0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO, for blocks that share one clock domain and need no pointer synchronisers.
- Adds a fill-level output, programmable almost-full and almost-empty flags, and a selectable first-word-fall-through read mode.
- Adds sticky overflow/underflow error flags.
- Storage is internal; all state is in one clock domain.

Parameters:
- DATA_SIZE, 12, width of wData/rData in bits.
- ADDR_SIZE, 4, address width; DEPTH = 2**ADDR_SIZE entries.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_THRESH, 2**ADDR_SIZE-2, wAlmostFull asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, rAlmostEmpty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- winc  input  1  write request.
- wData  input  DATA_SIZE  write data, captured when a write is accepted.
- rinc  input  1  read request (standard mode) or pop (FWFT mode).
- errClr  input  1  clears the sticky error flags.
- rData  output  DATA_SIZE  read data.
- wFull  output  1  count == DEPTH.
- rEmpty  output  1  count == 0.
- wAlmostFull  output  1  count >= AF_THRESH.
- rAlmostEmpty  output  1  count <= AE_THRESH.
- fillCount  output  ADDR_SIZE+1  current number of stored entries, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst=1 at an edge) forces:
  - write pointer, read pointer and count to 0;
  - rEmpty=1, rAlmostEmpty=1 (AE_THRESH>=0), wFull=0, wAlmostFull=0;
  - rData=0, overflow=0, underflow=0.
- Reset asserted mid-operation discards all contents. Memory contents are not cleared.
- Accept rules, evaluated against the flags as they stand before the edge:
  - write accepted iff winc && !wFull;
  - read accepted iff rinc && !rEmpty.
- Pointers are ADDR_SIZE+1 bit binary; the low ADDR_SIZE bits address storage. They wrap naturally from DEPTH-1 to 0 with no discontinuity in data order.
- Count update: count += wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
  - Full + winc + rinc: read accepted, write rejected, overflow set, count becomes DEPTH-1.
  - Empty + winc + rinc: write accepted, read rejected, underflow set, count becomes 1.
- All flags and fillCount are decoded from the registered count. They reflect an accepted operation in the cycle after its edge; there is no combinational path from winc/rinc to any flag.
- Standard mode (FWFT=0):
  - On an accepted read, rData is loaded with the head word at that edge, so data is valid the cycle after rinc (latency 1).
  - Otherwise rData holds its last value.
- FWFT mode (FWFT=1):
  - Whenever rEmpty=0, rData presents the head word with no request needed.
  - An accepted rinc pops it, and the next word (if any) appears the following cycle.
  - When rEmpty=1, rData holds its last value.
  - Write-to-visible latency is 1 cycle: a word written into an empty FIFO at edge N is on rData, with rEmpty=0, after edge N.
- Error flags:
  - overflow sets on any edge with winc && wFull; underflow sets on any edge with rinc && rEmpty.
  - errClr=1 clears both. If a set condition and errClr coincide, set wins.
  - Rejected operations never alter pointers, count or rData.
- Thresholds:
  - wAlmostFull and wFull may both be 1; rAlmostEmpty and rEmpty may both be 1.
  - Out-of-range thresholds are an elaboration error, checked with a static assertion.

Test Plan (DATA_SIZE=8, ADDR_SIZE=3, DEPTH=8, AF_THRESH=6, AE_THRESH=2):
- Reset then idle → rEmpty=1, rAlmostEmpty=1, wFull=0, wAlmostFull=0, fillCount=0, rData=0, overflow=0, underflow=0.
- Write 0x01..0x08 on 8 consecutive edges, FWFT=0 → fillCount 1..8; rAlmostEmpty drops after the 3rd write; wAlmostFull rises after the 6th; wFull after the 8th. Then 8 reads return 0x01..0x08, each one cycle after its rinc, and rEmpty=1 after the last.
- Full, then winc=1 for one edge → overflow=1, fillCount=8, contents unchanged. errClr=1 → overflow=0 next cycle.
- Full, then winc=rinc=1 with wData=0xAA → read returns the head word, fillCount=7, overflow=1, 0xAA never appears.
- FWFT=1, empty, write 0x5C → next cycle rEmpty=0 and rData=0x5C with no rinc. Then rinc=1 → rEmpty=1, fillCount=0.
- Wrap test: 20 write/read pairs at steady count 3 → data order preserved across pointer wrap. Then rst=1 mid-stream → fillCount=0 and rEmpty=1 the next cycle.
